// File: rtl/riscv_pkg.sv
// Shared encodings and the E-stage shadow record for the pipeline control logic.
// Constants and types only; no timing or flow control lives here.
package riscv_pkg;

  localparam int unsigned RF_AW = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic [RF_AW-1:0] rs1;
    logic [RF_AW-1:0] rs2;
    logic [RF_AW-1:0] rd;
    logic             reg_write;
    logic [1:0]       result_src;
  } e_stage_t;

endpackage

// File: rtl/hazard_fwd_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Registered output, one increment per edge with inc high; no backpressure.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// EX operand forwarding, load-use stall and branch flush for the 5-stage pipeline.
// Selects and stall/flush are combinational from shadow state; counters are registered.
module hazard_fwd_unit
  import riscv_pkg::*;
#(
  parameter int unsigned REG_AW = RF_AW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              reg_write_d,
  input  logic [1:0]        result_src_d,
  input  logic              pc_src_e,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [CNT_W-1:0]  load_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  e_stage_t          e_d, e_q;
  logic [REG_AW-1:0] rd_m_d, rd_m_q, rd_w_d, rd_w_q;
  logic              reg_write_m_d, reg_write_m_q;
  logic              reg_write_w_d, reg_write_w_q;
  logic              lw_stall;

  // M outranks W because it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              wr_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              wr_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if ((rs != '0) && (rs == rd_m) && wr_m) begin
      sel = FWD_M;
    end else if ((rs != '0) && (rs == rd_w) && wr_w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  assign forward_a_e = fwd_sel(e_q.rs1, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
  assign forward_b_e = fwd_sel(e_q.rs2, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);

  always_comb begin
    lw_stall = e_q.reg_write && (e_q.result_src == RES_MEM) && (e_q.rd != '0) &&
               ((rs1_d == e_q.rd) || (rs2_d == e_q.rd));
    stall_f  = lw_stall;
    stall_d  = lw_stall;
    flush_d  = pc_src_e;
    flush_e  = lw_stall | pc_src_e;
  end

  always_comb begin
    e_d = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d, reg_write: reg_write_d, result_src: result_src_d};
    if (flush_e) begin
      e_d = '{rs1: '0, rs2: '0, rd: '0, reg_write: 1'b0, result_src: RES_ALU};
    end
    rd_m_d        = e_q.rd;
    reg_write_m_d = e_q.reg_write;
    rd_w_d        = rd_m_q;
    reg_write_w_d = reg_write_m_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q           <= '0;
      rd_m_q        <= '0;
      reg_write_m_q <= 1'b0;
      rd_w_q        <= '0;
      reg_write_w_q <= 1'b0;
    end else begin
      e_q           <= e_d;
      rd_m_q        <= rd_m_d;
      reg_write_m_q <= reg_write_m_d;
      rd_w_q        <= rd_w_d;
      reg_write_w_q <= reg_write_w_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_load_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (lw_stall),
    .count (load_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_src_e),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed vectors with hand-computed expectations, checked by a negedge scoreboard monitor.
module tb_hazard_fwd_unit;

  localparam int CW = 2;
  localparam int OW = 8 + 2 * CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1_d, rs2_d, rd_d;
  logic          reg_write_d;
  logic [1:0]    result_src_d;
  logic          pc_src_e;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          stall_f, stall_d, flush_d, flush_e;
  logic [CW-1:0] load_stall_cnt, flush_cnt;

  typedef struct {
    int          id;
    logic [OW-1:0] exp;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks   = 0;
  int            failures = 0;
  int            vec_id   = 0;
  logic [OW-1:0] act;
  logic [OW-1:0] zero_out;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_d          (rs1_d),
    .rs2_d          (rs2_d),
    .rd_d           (rd_d),
    .reg_write_d    (reg_write_d),
    .result_src_d   (result_src_d),
    .pc_src_e       (pc_src_e),
    .forward_a_e    (forward_a_e),
    .forward_b_e    (forward_b_e),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .load_stall_cnt (load_stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  assign act = {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e,
                load_stall_cnt, flush_cnt};

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s {fa,fb,sf,sd,fd,fe,lcnt,fcnt} got=%b want=%b", name, got, want);
    end
  endtask

  // One pipeline cycle: drive the D-stage fields and queue what the outputs must be.
  task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic rw, input logic [1:0] rsrc, input logic pc,
                      input logic [1:0] efa, input logic [1:0] efb, input logic est,
                      input logic efd, input logic efe,
                      input logic [CW-1:0] elc, input logic [CW-1:0] efc);
    exp_t e;
    @(posedge clk);
    #1;
    rs1_d        = r1;
    rs2_d        = r2;
    rd_d         = rd;
    reg_write_d  = rw;
    result_src_d = rsrc;
    pc_src_e     = pc;
    vec_id++;
    e.id  = vec_id;
    e.exp = {efa, efb, est, est, efd, efe, elc, efc};
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check($sformatf("vec%0d", mon_e.id), act, mon_e.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_out     = '0;
    rst_n        = 1'b0;
    rs1_d        = '0;
    rs2_d        = '0;
    rd_d         = '0;
    reg_write_d  = 1'b0;
    result_src_d = 2'b00;
    pc_src_e     = 1'b0;
    #3;
    check("reset_initial", act, zero_out);
    #9;
    rst_n = 1'b1;

    // M forwarding, then W forwarding across one independent instruction
    step(1, 2, 5, 1, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(5, 6, 8, 1, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(0, 0, 0, 0, 2'b00, 0,  2'd2, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(0, 0, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(1, 2, 5, 1, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(1, 2, 9, 1, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(5, 0, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(0, 0, 0, 0, 2'b00, 0,  2'd1, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(0, 0, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);

    // back-to-back writers of x3: M wins over W
    step(1, 2, 3, 1, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(1, 2, 3, 1, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(0, 3, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(0, 0, 0, 0, 2'b00, 0,  2'd0, 2'd2, 0, 0, 0,  2'd0, 2'd0);
    step(0, 0, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);

    // loads into x0 followed by x0 readers: no forward, no stall
    step(0, 0, 0, 1, 2'b01, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(0, 0, 0, 1, 2'b01, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(0, 0, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(0, 0, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(0, 0, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);

    // load-use on x7: one stall cycle, then W forwarding
    step(1, 2, 7, 1, 2'b01, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(7, 0, 10, 1, 2'b00, 0, 2'd0, 2'd0, 1, 0, 1,  2'd0, 2'd0);
    step(7, 0, 10, 1, 2'b00, 0, 2'd0, 2'd0, 0, 0, 0,  2'd1, 2'd0);
    step(0, 0, 0, 0, 2'b00, 0,  2'd1, 2'd0, 0, 0, 0,  2'd1, 2'd0);
    step(0, 0, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd1, 2'd0);

    // taken branch squashes the x12 writer in D
    step(1, 2, 11, 1, 2'b00, 0, 2'd0, 2'd0, 0, 0, 0,  2'd1, 2'd0);
    step(1, 2, 12, 1, 2'b00, 1, 2'd0, 2'd0, 0, 1, 1,  2'd1, 2'd0);
    step(12, 0, 0, 0, 2'b00, 0, 2'd0, 2'd0, 0, 0, 0,  2'd1, 2'd1);
    step(0, 0, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd1, 2'd1);

    // five taken branches in a row saturate the 2-bit flush counter
    step(0, 0, 0, 0, 2'b00, 1,  2'd0, 2'd0, 0, 1, 1,  2'd1, 2'd1);
    step(0, 0, 0, 0, 2'b00, 1,  2'd0, 2'd0, 0, 1, 1,  2'd1, 2'd2);
    step(0, 0, 0, 0, 2'b00, 1,  2'd0, 2'd0, 0, 1, 1,  2'd1, 2'd3);
    step(0, 0, 0, 0, 2'b00, 1,  2'd0, 2'd0, 0, 1, 1,  2'd1, 2'd3);
    step(0, 0, 0, 0, 2'b00, 1,  2'd0, 2'd0, 0, 1, 1,  2'd1, 2'd3);
    step(1, 2, 5, 1, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd1, 2'd3);
    step(5, 0, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd1, 2'd3);
    step(0, 0, 0, 0, 2'b00, 0,  2'd2, 2'd0, 0, 0, 0,  2'd1, 2'd3);

    // asynchronous reset mid-cycle while forwarding state and counters are live
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", act, zero_out);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_held", act, zero_out);
    #2;
    rst_n = 1'b1;
    #1;
    check("reset_release", act, zero_out);

    // load-use coinciding with a taken branch
    step(1, 2, 7, 1, 2'b01, 0,  2'd0, 2'd0, 0, 0, 0,  2'd0, 2'd0);
    step(0, 7, 0, 0, 2'b00, 1,  2'd0, 2'd0, 1, 1, 1,  2'd0, 2'd0);
    step(0, 0, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd1, 2'd1);
    step(0, 0, 0, 0, 2'b00, 0,  2'd0, 2'd0, 0, 0, 0,  2'd1, 2'd1);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
